// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and its RAM.
package mem_pkg;

    localparam int WORD_W          = 32;
    localparam int CNT_W           = 4;
    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Point-to-point data-memory port between the datapath and the responder.
interface dmem_responder_if;
    import mem_pkg::*;

    logic [WORD_W-1:0] dAddr;
    logic [WORD_W-1:0] wData;
    logic              dReadMem;
    logic              dWriteMem;
    logic [WORD_W-1:0] rData;
    logic              Enable;
    logic              err;

    // Datapath side: issues requests, holds them while Enable is low.
    modport master (
        output dAddr, wData, dReadMem, dWriteMem,
        input  rData, Enable, err
    );

    // Memory side: serves requests and stalls the pipeline.
    modport slave (
        input  dAddr, wData, dReadMem, dWriteMem,
        output rData, Enable, err
    );

endinterface

// File: rtl/sp_ram.sv
// Single-port synchronous word RAM with a registered, resettable read port.
module sp_ram
    import mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wrData,
    output logic [WORD_W-1:0] rdData
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Array write port.
    // NOTE: the array has no reset on purpose; contents survive rst and a
    // per-word clear would stop this mapping onto a block RAM.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            mem[addr] <= wrData;
        end
    end

    // Registered read data; holds its value unless a read is requested.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves loads/stores with a fixed latency and holds
// the pipeline Enable low while an access is in flight.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int               ADDR_W   = clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic             ONE_SHOT = (LATENCY == 1);

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic              req;
    logic              isRead;
    logic              conflict;
    logic              misaligned;
    logic              ramRdEn;
    logic              ramWrEn;
    logic              errFlag;
    logic [ADDR_W-1:0] wordIdx;
    logic [WORD_W-1:0] ramRdData;

    // A simultaneous read+write is served as a write; low address bits and
    // index bits above the RAM size are simply dropped.
    assign req        = bus.dReadMem | bus.dWriteMem;
    assign isRead     = bus.dReadMem & ~bus.dWriteMem;
    assign conflict   = bus.dReadMem & bus.dWriteMem;
    assign misaligned = |bus.dAddr[1:0];
    assign wordIdx    = bus.dAddr[ADDR_W+1:2];

    // The store commits on the edge leaving DONE; a reset on that edge drops it.
    assign ramWrEn = rst & (state == DONE) & bus.dWriteMem;

    // Combinational from the request so the stall begins in the request cycle.
    assign bus.Enable = ~(req & (state != DONE));
    assign bus.rData  = ramRdData;
    assign bus.err    = errFlag;

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state, counter and RAM read-enable decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        stateNext = state;
        cntNext   = cnt;
        ramRdEn   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cntNext   = CNT_LOAD;
                    stateNext = ONE_SHOT ? DONE : WAIT;
                    ramRdEn   = isRead & ONE_SHOT;
                end
            end
            WAIT: begin
                if (!req) begin
                    // Flush: abandon the access without touching RAM or rData.
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    // Counter reaches zero on this edge: capture load data now.
                    stateNext = DONE;
                    cntNext   = '0;
                    ramRdEn   = isRead;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // Always return to IDLE so a still-held request is not re-served.
                stateNext = IDLE;
                cntNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Sticky error: conflicting or misaligned request seen since reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            errFlag <= 1'b0;
        end else if (req && (conflict || misaligned)) begin
            errFlag <= 1'b1;
        end
    end

    sp_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) ram (
        .clk   (clk),
        .rst   (rst),
        .wrEn  (ramWrEn),
        .rdEn  (ramRdEn),
        .addr  (wordIdx),
        .wrData(bus.wData),
        .rdData(ramRdData)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY = 2, DEPTH = 256).
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int LAT = 2;

    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH  (256),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
        bus.dReadMem  = rd;
        bus.dWriteMem = wr;
        bus.dAddr     = addr;
        bus.wData     = data;
    endtask

    // Idle cycles with no request: Enable must stay high.
    task automatic idle(input string tag, input int n);
        setReq(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s.en%0d", tag, i), {31'b0, bus.Enable}, 32'd1);
            tick();
        end
    endtask

    // One full access: Enable low for LAT cycles, high in DONE, rData checked in DONE.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] expRData);
        setReq(rd, wr, addr, data);
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            check($sformatf("%s.en%0d", tag, c), {31'b0, bus.Enable}, (c == LAT) ? 32'd1 : 32'd0);
            if (c == LAT) begin
                check($sformatf("%s.rData", tag), bus.rData, expRData);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog elapsed");
        $fatal(1, "watchdog");
    end

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst        = 1'b0;
        setReq(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset then idle.
        tick();
        @(negedge clk);
        check("rst.en", {31'b0, bus.Enable}, 32'd1);
        check("rst.rData", bus.rData, 32'h0);
        check("rst.err", {31'b0, bus.err}, 32'd0);
        tick();
        rst = 1'b1;
        idle("idle", 3);
        check("idle.rData", bus.rData, 32'h0);

        // Store then load.
        access("st40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
        idle("gap1", 1);
        access("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        idle("gap2", 1);
        check("ld40.err", {31'b0, bus.err}, 32'd0);

        // Wrap modulo DEPTH and misalignment.
        access("st404", 1'b0, 1'b1, 32'h404, 32'h11, 32'hDEADBEEF);
        idle("gap3", 1);
        access("ld004", 1'b1, 1'b0, 32'h004, 32'h0, 32'h11);
        idle("gap4", 1);
        check("wrap.err", {31'b0, bus.err}, 32'd0);
        access("ld006", 1'b1, 1'b0, 32'h006, 32'h0, 32'h11);
        check("mis.err", {31'b0, bus.err}, 32'd1);
        idle("gap5", 10);
        check("mis.errSticky", {31'b0, bus.err}, 32'd1);

        // Aborted store: old value survives, no extra stall.
        access("st80", 1'b0, 1'b1, 32'h80, 32'h12345678, 32'h11);
        idle("gap6", 1);
        setReq(1'b0, 1'b1, 32'h80, 32'h5A);
        @(negedge clk);
        check("abort.en0", {31'b0, bus.Enable}, 32'd0);
        tick();
        setReq(1'b0, 1'b0, 32'h80, 32'h5A);
        @(negedge clk);
        check("abort.en1", {31'b0, bus.Enable}, 32'd1);
        tick();
        @(negedge clk);
        check("abort.en2", {31'b0, bus.Enable}, 32'd1);
        check("abort.rData", bus.rData, 32'h11);
        tick();
        access("ld80", 1'b1, 1'b0, 32'h80, 32'h0, 32'h12345678);

        // Back-to-back store then load of the same word.
        access("st44", 1'b0, 1'b1, 32'h44, 32'h0BADF00D, 32'h12345678);
        access("ld44", 1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D);
        idle("gap7", 1);

        // Reset during WAIT of a store to 0x10.
        access("st10", 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 32'h0BADF00D);
        idle("gap8", 1);
        setReq(1'b0, 1'b1, 32'h10, 32'hBAD0BAD0);
        @(negedge clk);
        check("rstW.en0", {31'b0, bus.Enable}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstW.en1", {31'b0, bus.Enable}, 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstW.enHeld", {31'b0, bus.Enable}, 32'd0);
        check("rstW.rData", bus.rData, 32'h0);
        check("rstW.err", {31'b0, bus.err}, 32'd0);
        tick();
        setReq(1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("rstW.enDrop", {31'b0, bus.Enable}, 32'd1);
        tick();
        access("ld10a", 1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D);
        idle("gap9", 1);

        // Reset during DONE of a store: write must not commit.
        setReq(1'b0, 1'b1, 32'h10, 32'hBAD0BAD0);
        @(negedge clk);
        check("rstD.en0", {31'b0, bus.Enable}, 32'd0);
        tick();
        @(negedge clk);
        check("rstD.en1", {31'b0, bus.Enable}, 32'd0);
        tick();
        @(negedge clk);
        check("rstD.en2", {31'b0, bus.Enable}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        setReq(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstD.rData", bus.rData, 32'h0);
        tick();
        access("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D);
        idle("gap10", 1);
        check("preConf.err", {31'b0, bus.err}, 32'd0);

        // Conflicting request is a write and raises err.
        access("conf20", 1'b1, 1'b1, 32'h20, 32'h77, 32'hCAFEF00D);
        idle("gap11", 1);
        check("conf.err", {31'b0, bus.err}, 32'd1);
        access("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h77);
        idle("tail", 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
